// File: rtl/jio_pkg.sv
// Shared IO bus definitions for the CPU control unit and the device-side responder.
package jio_pkg;

  localparam logic IO_OUT  = 1'b1;
  localparam logic IO_IN   = 1'b0;
  localparam logic IO_ADDR = 1'b1;
  localparam logic IO_DATA = 1'b0;

  localparam logic [7:0] DEF_TTY_ADDR = 8'h01;
  localparam logic [7:0] DEF_KBD_ADDR = 8'h02;

  typedef enum logic [1:0] {
    IO_IN_DATA  = {IO_IN,  IO_DATA},
    IO_IN_ADDR  = {IO_IN,  IO_ADDR},
    IO_OUT_DATA = {IO_OUT, IO_DATA},
    IO_OUT_ADDR = {IO_OUT, IO_ADDR}
  } io_cycle_e;

  function automatic io_cycle_e io_decode(input logic io_io, input logic io_da);
    return io_cycle_e'({io_io, io_da});
  endfunction

  // The CPU numbers bus bits MSB-first, so bus bit i is device bit 7-i.
  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/jio_fifo.sv
// Small synchronous FIFO with a combinational head; pop is resolved before push.
module jio_fifo
  import jio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    head    = mem[rd_ptr];
    do_pop  = pop & ~empty;
    // A pop frees the slot that a same-cycle push into a full queue needs.
    do_push = push & (~full | do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jio_responder.sv
// Device-side end of the CPU IO bus: address select, TTY output queue and keyboard
// holding register, driven by the CPU set/enable strobes.
module jio_responder
  import jio_pkg::*;
#(
  parameter logic [7:0]  TTY_ADDR   = DEF_TTY_ADDR,
  parameter logic [7:0]  KBD_ADDR   = DEF_KBD_ADDR,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK_clk,
  input  logic       reset,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_io,
  input  logic       io_da,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       overflow
);

  io_cycle_e  cycle;
  logic       s_q, e_q, s_rise, e_rise;
  logic [7:0] sel_addr, kbd_byte, push_byte;
  logic       kbd_full, consume;
  logic       push_req, pop, fifo_full, fifo_empty;

  always_comb begin
    cycle     = io_decode(io_io, io_da);
    s_rise    = io_s & ~s_q;
    e_rise    = io_e & ~e_q;
    push_req  = s_rise && (cycle == IO_OUT_DATA) && (sel_addr == TTY_ADDR);
    push_byte = bit_rev(bus_in);
    pop       = tx_ready & ~fifo_empty;
    tx_valid  = ~fifo_empty;
    rx_ready  = ~kbd_full;
    bus_oe    = io_e && (cycle == IO_IN_DATA) && (sel_addr == KBD_ADDR);
    consume   = e_rise & bus_oe;
    bus_out   = '0;
    if (bus_oe && kbd_full) bus_out = bit_rev(kbd_byte);
  end

  // Strobe-delay flops reset high so a strobe held across reset release is not an edge.
  always_ff @(posedge CLK_clk) begin
    if (reset) begin
      s_q      <= 1'b1;
      e_q      <= 1'b1;
      sel_addr <= '0;
      kbd_byte <= '0;
      kbd_full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s_q <= io_s;
      e_q <= io_e;
      if (s_rise && (cycle == IO_OUT_ADDR)) sel_addr <= bit_rev(bus_in);
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      if (consume) kbd_full <= 1'b0;
      if (rx_valid && !kbd_full) begin
        kbd_byte <= rx_data;
        kbd_full <= 1'b1;
      end
    end
  end

  jio_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_byte),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .head  (tx_data)
  );

endmodule

// File: tb/tb_jio_responder.sv
// Directed bench for jio_responder: table of bus cycles plus hand-written keyboard
// and full-queue sequences. Bus values are written in CPU (MSB-first) numbering.
module tb_jio_responder;

  logic       clk = 1'b0;
  logic       reset, io_s, io_e, io_io, io_da;
  logic [7:0] bus_in, bus_out, tx_data, rx_data;
  logic       bus_oe, tx_valid, tx_ready, rx_valid, rx_ready, overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  jio_responder #(
    .TTY_ADDR   (8'h01),
    .KBD_ADDR   (8'h02),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_clk  (clk),
    .reset    (reset),
    .io_s     (io_s),
    .io_e     (io_e),
    .io_io    (io_io),
    .io_da    (io_da),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overflow (overflow)
  );

  typedef enum {OP_OUT_ADDR, OP_OUT_DATA, OP_IN_ADDR, OP_IN_DATA, OP_POP} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       exp_valid;
    logic [7:0] exp_head;
    logic       exp_ovf;
    logic       exp_oe;
    logic [7:0] exp_out;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = {<<{v}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_cycle(input logic da, input logic [7:0] v);
    io_io  = 1'b1;
    io_da  = da;
    bus_in = rev8(v);
    io_s   = 1'b1;
    tick();
    io_s = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_OUT_ADDR, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{OP_OUT_DATA, 8'h41, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{OP_POP,      8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{OP_OUT_DATA, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{OP_OUT_DATA, 8'h11, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{OP_OUT_DATA, 8'h12, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{OP_OUT_DATA, 8'h13, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{OP_OUT_DATA, 8'h14, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{OP_POP,      8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{OP_POP,      8'h00, 1'b1, 8'h12, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{OP_POP,      8'h00, 1'b1, 8'h13, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{OP_POP,      8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{OP_OUT_ADDR, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{OP_OUT_DATA, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{OP_IN_ADDR,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[15] = '{OP_IN_DATA,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

    // Reset held three cycles with a set strobe (OUT Addr 01) asserted throughout.
    reset = 1'b1; io_s = 1'b1; io_e = 1'b0; io_io = 1'b1; io_da = 1'b1;
    bus_in = rev8(8'h01); tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick(); tick();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_bus_oe", bus_oe, 1'b0);
    chk("rst_bus_out", bus_out, 8'h00);
    reset = 1'b0;
    tick(); tick();
    io_s = 1'b0;
    tick();
    // Had the held strobe fired, TTY would be selected and this byte queued.
    out_cycle(1'b0, 8'h41);
    chk("no_push_after_reset", tx_valid, 1'b0);

    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.op == OP_POP) begin
        tx_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_bus_oe", i), bus_oe, v.exp_oe);
        chk($sformatf("v%0d_bus_out", i), rev8(bus_out), v.exp_out);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
      end else begin
        io_io  = (v.op == OP_OUT_ADDR) || (v.op == OP_OUT_DATA);
        io_da  = (v.op == OP_OUT_ADDR) || (v.op == OP_IN_ADDR);
        bus_in = rev8(v.data);
        if (io_io) io_s = 1'b1;
        else       io_e = 1'b1;
        #1;
        chk($sformatf("v%0d_bus_oe", i), bus_oe, v.exp_oe);
        chk($sformatf("v%0d_bus_out", i), rev8(bus_out), v.exp_out);
        @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d_tx_valid", i), tx_valid, v.exp_valid);
      if (v.exp_valid) chk($sformatf("v%0d_tx_data", i), tx_data, v.exp_head);
      chk($sformatf("v%0d_overflow", i), overflow, v.exp_ovf);
      if (v.op != OP_POP) begin
        io_s = 1'b0;
        io_e = 1'b0;
        tick();
      end
    end

    // Keyboard load, IN Data consume, and an IN Data on an empty holding register.
    rx_data = 8'h5A; rx_valid = 1'b1;
    #1;
    chk("kbd_ready_empty", rx_ready, 1'b1);
    tick();
    rx_valid = 1'b0;
    chk("kbd_ready_full", rx_ready, 1'b0);
    out_cycle(1'b1, 8'h02);
    io_io = 1'b0; io_da = 1'b0; io_e = 1'b1;
    #1;
    chk("kbd_in_oe", bus_oe, 1'b1);
    chk("kbd_in_byte", rev8(bus_out), 8'h5A);
    tick();
    chk("kbd_ready_after_consume", rx_ready, 1'b1);
    chk("kbd_oe_level", bus_oe, 1'b1);
    chk("kbd_out_after_consume", rev8(bus_out), 8'h00);
    io_e = 1'b0;
    tick();
    chk("kbd_oe_released", bus_oe, 1'b0);
    io_e = 1'b1;
    #1;
    chk("kbd_second_oe", bus_oe, 1'b1);
    chk("kbd_second_byte", rev8(bus_out), 8'h00);
    tick();
    io_e = 1'b0;
    tick();

    // Full queue with a push and pop in the same cycle.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst2_overflow", overflow, 1'b0);
    chk("rst2_tx_valid", tx_valid, 1'b0);
    out_cycle(1'b1, 8'h01);
    for (int k = 0; k < 4; k++) out_cycle(1'b0, 8'hA0 + 8'(k));
    chk("full_head", tx_data, 8'hA0);
    io_io = 1'b1; io_da = 1'b0; bus_in = rev8(8'hA4); io_s = 1'b1; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("pushpop_overflow", overflow, 1'b0);
    chk("pushpop_head", tx_data, 8'hA1);
    io_s = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d_valid", k), tx_valid, 1'b1);
      chk($sformatf("drain%0d_data", k), tx_data, 8'hA0 + 8'(k));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("drain_empty", tx_valid, 1'b0);
    chk("drain_overflow", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
